// File: rtl/mem_stage_sram.sv
// -----------------------------------------------------------------------------
// mem_stage_sram
//   MEM pipeline stage in front of a 16-bit asynchronous SRAM. A 32-bit load or
//   store is split into two halfword accesses. The pipeline stalls until the
//   access completes. The MEM/WB register loads the instruction when ready=1
//   and loads a bubble (WB_en=0, MEM_R_en=0) while the stage is stalled.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   PC_in .. WB_en_in : EXE/MEM register fields (held stable while ready=0)
//   PC .. WB_en       : registered MEM/WB fields for the WB stage
//   ready             : combinational; 0 freezes PC, IF/ID, ID/EXE and EXE/MEM
//   SRAM_ADDR         : halfword address (0 when no access is in progress)
//   SRAM_DQ_out       : write data driven during write states
//   SRAM_DQ_oe        : data bus drive enable (write states only)
//   SRAM_WE_N         : active-low write strobe (write states only)
//   SRAM_DQ_in        : read data, valid in the same cycle as SRAM_ADDR
// -----------------------------------------------------------------------------
module mem_stage_sram (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] PC_in,
  input  logic [3:0]  Dest_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        MEM_R_en_in,
  input  logic        MEM_W_en_in,
  input  logic        WB_en_in,

  output logic [31:0] PC,
  output logic [3:0]  Dest,
  output logic [31:0] ALU_result,
  output logic [31:0] MEM_result,
  output logic        MEM_R_en,
  output logic        WB_en,

  output logic        ready,

  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  input  logic [15:0] SRAM_DQ_in
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned WORD_W    = ADDR_W - 1;
  localparam int unsigned DEST_W    = 4;
  localparam int unsigned SRAM_BASE = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_result;
    logic              mem_r_en;
    logic              wb_en;
  } mem_wb_t;

  state_t            state_q;
  state_t            state_d;
  logic [HALF_W-1:0] lo_q;
  logic [HALF_W-1:0] hi_q;
  logic              lo_en;
  logic              hi_en;
  mem_wb_t           mem_wb_q;

  // Byte address -> 32-bit word index inside the SRAM window.
  logic [DATA_W-1:0] off;
  logic [WORD_W-1:0] word;
  logic              unused_off;

  assign off        = ALU_result_in - DATA_W'(SRAM_BASE);
  assign word       = off[18:2];
  // Byte offset within the word and bits above the SRAM window are don't-care.
  assign unused_off = ^{off[31:19], off[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, SRAM strobes and ready.
  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    lo_en       = 1'b0;
    hi_en       = 1'b0;

    case (state_q)
      IDLE: begin
        // A load wins when both enables are asserted; the store is dropped.
        if (MEM_R_en_in) begin
          state_d = RD_LO;
        end else if (MEM_W_en_in) begin
          state_d = WR_LO;
        end else begin
          ready = 1'b1;
        end
      end

      RD_LO: begin
        SRAM_ADDR = {word, 1'b0};
        lo_en     = 1'b1;
        state_d   = RD_HI;
      end

      RD_HI: begin
        SRAM_ADDR = {word, 1'b1};
        hi_en     = 1'b1;
        state_d   = DONE;
      end

      WR_LO: begin
        SRAM_ADDR   = {word, 1'b0};
        SRAM_DQ_out = Val_Rm_in[HALF_W-1:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
        state_d     = WR_HI;
      end

      WR_HI: begin
        SRAM_ADDR   = {word, 1'b1};
        SRAM_DQ_out = Val_Rm_in[DATA_W-1:HALF_W];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
        state_d     = DONE;
      end

      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read halves captured from the asynchronous SRAM at the end of each read state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (lo_en) begin
        lo_q <= SRAM_DQ_in;
      end
      if (hi_en) begin
        hi_q <= SRAM_DQ_in;
      end
    end
  end

  // MEM/WB register: real instruction when ready, otherwise a bubble that keeps
  // the data fields but kills both enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_q <= '0;
    end else if (ready) begin
      mem_wb_q.pc         <= PC_in;
      mem_wb_q.dest       <= Dest_in;
      mem_wb_q.alu_result <= ALU_result_in;
      mem_wb_q.mem_result <= MEM_R_en_in ? {hi_q, lo_q} : '0;
      mem_wb_q.mem_r_en   <= MEM_R_en_in;
      mem_wb_q.wb_en      <= WB_en_in;
    end else begin
      mem_wb_q.mem_r_en   <= 1'b0;
      mem_wb_q.wb_en      <= 1'b0;
    end
  end

  assign PC         = mem_wb_q.pc;
  assign Dest       = mem_wb_q.dest;
  assign ALU_result = mem_wb_q.alu_result;
  assign MEM_result = mem_wb_q.mem_result;
  assign MEM_R_en   = mem_wb_q.mem_r_en;
  assign WB_en      = mem_wb_q.wb_en;

endmodule

// File: tb/tb_mem_stage_sram.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram
//   Bench for mem_stage_sram: async SRAM model, vector tables for pass-through
//   ops and address mapping, directed load/store/reset sequences and a random
//   instruction stream checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram;

  localparam int unsigned SRAM_WORDS = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in;
  logic [3:0]  Dest_in;
  logic [31:0] ALU_result_in;
  logic [31:0] Val_Rm_in;
  logic        MEM_R_en_in;
  logic        MEM_W_en_in;
  logic        WB_en_in;
  logic [31:0] PC;
  logic [3:0]  Dest;
  logic [31:0] ALU_result;
  logic [31:0] MEM_result;
  logic        MEM_R_en;
  logic        WB_en;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DQ_in;

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk           (clk),
    .rst           (rst),
    .PC_in         (PC_in),
    .Dest_in       (Dest_in),
    .ALU_result_in (ALU_result_in),
    .Val_Rm_in     (Val_Rm_in),
    .MEM_R_en_in   (MEM_R_en_in),
    .MEM_W_en_in   (MEM_W_en_in),
    .WB_en_in      (WB_en_in),
    .PC            (PC),
    .Dest          (Dest),
    .ALU_result    (ALU_result),
    .MEM_result    (MEM_result),
    .MEM_R_en      (MEM_R_en),
    .WB_en         (WB_en),
    .ready         (ready),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_DQ_out   (SRAM_DQ_out),
    .SRAM_DQ_oe    (SRAM_DQ_oe),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_DQ_in    (SRAM_DQ_in)
  );

  // Asynchronous SRAM: combinational read, written by the stimulus process.
  logic [15:0] sram_mem [0:SRAM_WORDS-1];
  logic [15:0] ref_mem  [0:SRAM_WORDS-1];
  assign SRAM_DQ_in = sram_mem[SRAM_ADDR];

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] val;
    logic        r;
    logic        w;
    logic        wb;
    bit          gap;
  } instr_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] mres;
    logic        r;
    logic        wb;
  } commit_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic        wb;
    logic [31:0] exp_pc;
    logic [3:0]  exp_dest;
    logic [31:0] exp_alu;
    logic        exp_wb;
  } alu_vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [17:0] exp_lo;
    logic [17:0] exp_hi;
  } addr_vec_t;

  int      total = 0;
  int      bad   = 0;
  commit_t committed;
  commit_t snap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Halfword address of the low half, straight from the address arithmetic rule.
  function automatic logic [17:0] lo_addr(input logic [31:0] alu);
    logic [31:0] off;
    off = alu - 32'd1024;
    return 18'(((off / 32'd4) % 32'd131072) * 32'd2);
  endfunction

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 7 + 3);
  endfunction

  task automatic preload(input int a, input logic [15:0] d);
    sram_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  task automatic drive(input instr_t t);
    PC_in         = t.pc;
    Dest_in       = t.dest;
    ALU_result_in = t.alu;
    Val_Rm_in     = t.val;
    MEM_R_en_in   = t.r;
    MEM_W_en_in   = t.w;
    WB_en_in      = t.wb;
  endtask

  task automatic drive_idle();
    MEM_R_en_in = 1'b0;
    MEM_W_en_in = 1'b0;
    WB_en_in    = 1'b0;
  endtask

  task automatic sram_service();
    if (SRAM_WE_N === 1'b0) sram_mem[SRAM_ADDR] = SRAM_DQ_out;
  endtask

  task automatic take_snap();
    snap = '{PC, Dest, ALU_result, MEM_result, MEM_R_en, WB_en};
  endtask

  task automatic check_commit(input string tag);
    chk({tag, ".pc"},   PC,         committed.pc);
    chk({tag, ".dest"}, 32'(Dest),  32'(committed.dest));
    chk({tag, ".alu"},  ALU_result, committed.alu);
    chk({tag, ".mres"}, MEM_result, committed.mres);
    chk({tag, ".r"},    32'(MEM_R_en), 32'(committed.r));
    chk({tag, ".wb"},   32'(WB_en),    32'(committed.wb));
  endtask

  task automatic check_bubble();
    chk("bubble.pc",   PC,         committed.pc);
    chk("bubble.dest", 32'(Dest),  32'(committed.dest));
    chk("bubble.alu",  ALU_result, committed.alu);
    chk("bubble.mres", MEM_result, committed.mres);
    chk("bubble.r",    32'(MEM_R_en), 32'd0);
    chk("bubble.wb",   32'(WB_en),    32'd0);
  endtask

  // Drive zeros in IDLE for one edge; the MEM/WB register then holds zeros.
  task automatic resync();
    instr_t z;
    z = '{32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(z);
    @(posedge clk); #1;
    committed = '{32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0};
  endtask

  // Runs one instruction starting at posedge+1 with the FSM in IDLE.
  // Memory ops take four cycles, others one; ready only on the last.
  task automatic run_instr(input instr_t t);
    bit          mem_op;
    bit          st_only;
    bit          wr;
    int          nc;
    logic [17:0] la;
    logic [17:0] ea;
    logic [31:0] ld;
    mem_op  = t.r | t.w;
    st_only = t.w & ~t.r;
    nc      = mem_op ? 4 : 1;
    la      = lo_addr(t.alu);
    ld      = {ref_mem[18'(la + 18'd1)], ref_mem[la]};
    if (st_only) begin
      ref_mem[la]                = t.val[15:0];
      ref_mem[18'(la + 18'd1)]   = t.val[31:16];
    end
    drive(t);
    for (int c = 0; c < nc; c++) begin
      @(negedge clk);
      if (c == 0) check_commit("commit"); else check_bubble();
      chk("ready", 32'(ready), 32'(c == nc - 1));
      ea = (mem_op && c == 1) ? la : (mem_op && c == 2) ? (la | 18'd1) : 18'd0;
      chk("sram_addr", 32'(SRAM_ADDR), 32'(ea));
      wr = st_only && (c == 1 || c == 2);
      chk("we_n", 32'(SRAM_WE_N), 32'(!wr));
      chk("oe",   32'(SRAM_DQ_oe), 32'(wr));
      if (wr) chk("dq_out", 32'(SRAM_DQ_out), (c == 1) ? 32'(t.val[15:0]) : 32'(t.val[31:16]));
      sram_service();
      @(posedge clk); #1;
    end
    committed = '{t.pc, t.dest, t.alu, (t.r ? ld : 32'd0), t.r, t.wb};
    if (t.gap) begin
      drive_idle();
      @(negedge clk);
      check_commit("gap");
      chk("gap.ready", 32'(ready), 32'd1);
      take_snap();
      sram_service();
      @(posedge clk); #1;
      committed.mres = 32'd0;
      committed.r    = 1'b0;
      committed.wb   = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    alu_vec_t  alu_tab [4];
    addr_vec_t addr_tab[8];
    instr_t    t;
    int        kind;

    alu_tab[0] = '{32'h0000_1000, 4'd1,  32'h0000_0005, 1'b1, 32'h0000_1000, 4'd1,  32'h0000_0005, 1'b1};
    alu_tab[1] = '{32'h0000_1004, 4'd15, 32'hFFFF_FFFF, 1'b0, 32'h0000_1004, 4'd15, 32'hFFFF_FFFF, 1'b0};
    alu_tab[2] = '{32'hABCD_0000, 4'd9,  32'h8000_0001, 1'b1, 32'hABCD_0000, 4'd9,  32'h8000_0001, 1'b1};
    alu_tab[3] = '{32'h0000_100C, 4'd0,  32'h0000_0400, 1'b1, 32'h0000_100C, 4'd0,  32'h0000_0400, 1'b1};

    addr_tab[0] = '{32'd1024,              18'h00000, 18'h00001};
    addr_tab[1] = '{32'd1032,              18'h00004, 18'h00005};
    addr_tab[2] = '{32'd1027,              18'h00000, 18'h00001};
    addr_tab[3] = '{32'd1028,              18'h00002, 18'h00003};
    addr_tab[4] = '{32'd1024 + 32'h80000,  18'h00000, 18'h00001};
    addr_tab[5] = '{32'd1020,              18'h3FFFE, 18'h3FFFF};
    addr_tab[6] = '{32'd1024 + 32'h7FFFC,  18'h3FFFE, 18'h3FFFF};
    addr_tab[7] = '{32'd1024 + 32'h100,    18'h00080, 18'h00081};

    for (int i = 0; i < SRAM_WORDS; i++) begin
      sram_mem[i] = init_val(i);
      ref_mem[i]  = init_val(i);
    end

    // Reset
    rst = 1'b1;
    t = '{32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(t);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    committed = '{32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    @(negedge clk);
    check_commit("reset");
    chk("reset.ready", 32'(ready), 32'd1);
    chk("reset.we_n",  32'(SRAM_WE_N), 32'd1);
    chk("reset.oe",    32'(SRAM_DQ_oe), 32'd0);
    chk("reset.addr",  32'(SRAM_ADDR), 32'd0);
    @(posedge clk); #1;
    resync();

    // Pass-through vectors
    for (int i = 0; i < 4; i++) begin
      t = '{alu_tab[i].pc, alu_tab[i].dest, alu_tab[i].alu, 32'h0, 1'b0, 1'b0, alu_tab[i].wb, 1'b0};
      drive(t);
      @(negedge clk);
      chk("tab.ready", 32'(ready), 32'd1);
      chk("tab.we_n",  32'(SRAM_WE_N), 32'd1);
      chk("tab.addr",  32'(SRAM_ADDR), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tab.pc",   PC, alu_tab[i].exp_pc);
      chk("tab.dest", 32'(Dest), 32'(alu_tab[i].exp_dest));
      chk("tab.alu",  ALU_result, alu_tab[i].exp_alu);
      chk("tab.wb",   32'(WB_en), 32'(alu_tab[i].exp_wb));
      chk("tab.mres", MEM_result, 32'd0);
      chk("tab.r",    32'(MEM_R_en), 32'd0);
      @(posedge clk); #1;
    end
    resync();

    // Directed load
    preload(4, 16'hBEEF);
    preload(5, 16'hDEAD);
    run_instr('{32'h0000_0100, 4'd3, 32'd1032, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1});
    chk("load.mres", snap.mres, 32'hDEADBEEF);
    chk("load.r",    32'(snap.r),  32'd1);
    chk("load.wb",   32'(snap.wb), 32'd1);

    // Directed store
    run_instr('{32'h0000_0104, 4'd0, 32'd1024, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("store.lo", 32'(sram_mem[0]), 32'h5678);
    chk("store.hi", 32'(sram_mem[1]), 32'h1234);
    chk("store.wb", 32'(snap.wb), 32'd0);

    // Directed ALU op
    run_instr('{32'h0000_0108, 4'd7, 32'd99, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    chk("alu.dest", 32'(snap.dest), 32'd7);
    chk("alu.val",  snap.alu, 32'd99);
    chk("alu.wb",   32'(snap.wb), 32'd1);

    // Read and write both requested: read wins
    preload(2, 16'hA5A5);
    preload(3, 16'h5A5A);
    run_instr('{32'h0000_010C, 4'd2, 32'd1028, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1, 1'b1});
    chk("both.mres", snap.mres, 32'h5A5A_A5A5);
    chk("both.sram2", 32'(sram_mem[2]), 32'hA5A5);
    chk("both.sram3", 32'(sram_mem[3]), 32'h5A5A);

    // Reset in the middle of a store
    preload(32'h401, 16'h7777);
    t = '{32'h0000_0110, 4'd5, 32'd1024 + 32'h800, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0};
    drive(t);
    @(negedge clk);
    chk("rstw.ready0", 32'(ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.we_lo", 32'(SRAM_WE_N), 32'd0);
    sram_service();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("rstw.we_n",  32'(SRAM_WE_N), 32'd1);
    chk("rstw.oe",    32'(SRAM_DQ_oe), 32'd0);
    chk("rstw.addr",  32'(SRAM_ADDR), 32'd0);
    chk("rstw.ready", 32'(ready), 32'd1);
    committed = '{32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    check_commit("rstw");
    sram_service();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.we_n2", 32'(SRAM_WE_N), 32'd1);
    chk("rstw.no_hi", 32'(sram_mem[32'h401]), 32'h7777);
    @(posedge clk); #1;
    resync();

    // Address mapping vectors (loads)
    for (int i = 0; i < 8; i++) begin
      t = '{32'h200 + 32'(i), 4'd1, addr_tab[i].alu, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
      drive(t);
      @(negedge clk);
      chk("map.addr0", 32'(SRAM_ADDR), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("map.lo", 32'(SRAM_ADDR), 32'(addr_tab[i].exp_lo));
      @(posedge clk); #1;
      @(negedge clk);
      chk("map.hi", 32'(SRAM_ADDR), 32'(addr_tab[i].exp_hi));
      @(posedge clk); #1;
      @(negedge clk);
      chk("map.ready", 32'(ready), 32'd1);
      drive_idle();
      @(posedge clk); #1;
    end
    resync();

    // Random instruction stream against the reference model
    for (int n = 0; n < 150; n++) begin
      kind  = (($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2)));
      t.pc  = $urandom;
      t.dest = 4'($urandom_range(0, 15));
      t.val = $urandom;
      t.gap = ($urandom_range(0, 3) == 0) || (n == 149);
      if (kind == 0) begin
        t.alu = $urandom;
        t.r = 1'b0; t.w = 1'b0; t.wb = 1'($urandom_range(0, 1));
      end else begin
        t.alu = 32'd1024 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3))
              + ($urandom_range(0, 1) ? 32'h0008_0000 * 32'($urandom_range(1, 3)) : 32'd0);
        t.r  = (kind == 1 || kind == 3);
        t.w  = (kind == 2 || kind == 3);
        t.wb = t.r;
      end
      run_instr(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
- clk: input, 1 bit, rising-edge clock.
- rst: input, 1 bit, synchronous active-high reset.
REQ-002 Inputs from the EXE/MEM register SHALL be:
- PC_in: input, 32, instruction PC.
- Dest_in: input, 4, destination register.
- ALU_result_in: input, 32, ALU result / memory byte address.
- Val_Rm_in: input, 32, store data.
- MEM_R_en_in: input, 1, load.
- MEM_W_en_in: input, 1, store.
- WB_en_in: input, 1, register write-back enable.
REQ-003 Registered MEM/WB outputs feeding the WB stage SHALL be:
- PC: output, 32.
- Dest: output, 4.
- ALU_result: output, 32.
- MEM_result: output, 32.
- MEM_R_en: output, 1.
- WB_en: output, 1.
REQ-004 ready SHALL be an output, 1 bit, combinational; 0 means freeze PC, IF/ID, ID/EXE and EXE/MEM.
REQ-005 SRAM-side ports SHALL be:
- SRAM_ADDR: output, 18, halfword address.
- SRAM_DQ_out: output, 16, write data.
- SRAM_DQ_oe: output, 1, data bus drive enable.
- SRAM_WE_N: output, 1, active-low write strobe.
- SRAM_DQ_in: input, 16, read data from an asynchronous SRAM (valid in the same cycle as SRAM_ADDR).

Function
REQ-006 Address mapping SHALL be off = ALU_result_in - 1024 (32-bit wrap), word = off[18:2], low half at {word,1'b0}, high half at {word,1'b1}; off[1:0] and off[31:19] are ignored.
REQ-007 The FSM SHALL have exactly six states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-008 In IDLE:
- MEM_R_en_in=1 SHALL transition to RD_LO.
- Otherwise MEM_W_en_in=1 SHALL transition to WR_LO.
- With both asserted, the read SHALL take priority and no SRAM write occurs.
- Otherwise the FSM SHALL stay in IDLE.
REQ-009 Read sequence:
- RD_LO drives the low-half address and captures SRAM_DQ_in into lo[15:0] at the clock edge.
- RD_HI drives the high-half address, captures hi[15:0], then goes to DONE.
REQ-010 Write sequence:
- WR_LO drives the low-half address, SRAM_DQ_out=Val_Rm_in[15:0], SRAM_WE_N=0 and SRAM_DQ_oe=1.
- WR_HI does the same with Val_Rm_in[31:16] at the high-half address, then goes to DONE.
REQ-011 DONE SHALL transition unconditionally to IDLE after one cycle.
REQ-012 SRAM_WE_N SHALL be 0 only in WR_LO and WR_HI; SRAM_DQ_oe SHALL be 1 only in those states; SRAM_ADDR SHALL be 0 in IDLE and DONE.
REQ-013 ready SHALL be 1 in DONE, 1 in IDLE when MEM_R_en_in=0 and MEM_W_en_in=0, and 0 otherwise.
REQ-014 Load or store latency SHALL be 4 cycles: IDLE (request seen) -> LO -> HI -> DONE, with ready=1 only in DONE.
REQ-015 On each rising edge with ready=1, the MEM/WB register SHALL load:
- PC, Dest, ALU_result, MEM_R_en and WB_en from the corresponding inputs.
- MEM_result = {hi,lo} for a load, or 0 otherwise.
REQ-016 On each rising edge with ready=0, the MEM/WB register SHALL load a bubble: WB_en=0, MEM_R_en=0, with other fields holding their previous values.
REQ-017 Non-memory instructions SHALL pass through in one cycle with no SRAM activity.
REQ-018 EXE/MEM inputs are held stable by upstream while ready=0; the block SHALL sample address and store data combinationally each cycle.

Reset
REQ-019 When rst=1 at a rising edge, the FSM SHALL go to IDLE, lo and hi SHALL clear to 0, and all MEM/WB outputs SHALL clear to 0.
REQ-020 A reset in any state, including mid-write, SHALL make SRAM_WE_N=1 and SRAM_DQ_oe=0 from the next cycle, with no completion of the access.
REQ-021 After reset release, ready SHALL follow REQ-013 immediately.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load: ALU_result_in=1032, SRAM[4]=16'hBEEF, SRAM[5]=16'hDEAD -> SRAM_ADDR 4 then 5; ready 0,0,0,1; after DONE, MEM_result=32'hDEADBEEF, MEM_R_en=1, WB_en=1.
- Store: ALU_result_in=1024, Val_Rm_in=32'h12345678 -> WE_N low for 2 cycles; SRAM[0]=16'h5678, SRAM[1]=16'h1234; WB_en=0 after DONE.
- ALU op: WB_en_in=1, Dest_in=4'd7, ALU_result_in=32'd99 -> next cycle Dest=7, ALU_result=99, WB_en=1; ready stays 1; SRAM_WE_N stays 1.
- Bubble: during the load stall cycles, WB_en=0 and MEM_R_en=0 at the outputs; exactly one cycle with WB_en=1 per load.
- Reset mid-store: rst=1 while in WR_LO -> next cycle SRAM_WE_N=1, oe=0, all outputs 0, ready=1 when there is no request.
- Both R and W asserted, address 1028 -> read of SRAM[2] and SRAM[3]; SRAM_WE_N never low.
